// File: rtl/ysyx_23060184_lsu_if.sv
// AXI4-Lite-style data-memory port between the LSU (master) and memory (slave).
interface ysyx_23060184_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060184_lsu.sv
// Memory-stage load/store unit: runs one bus transaction per instruction, aligns and
// extends load data, and hands the result to writeback with a valid/ready handshake.
module ysyx_23060184_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  InValidM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            RopcodeM,
    input  logic [3:0]            WmaskM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  Wready,
    output logic                  Mready,
    output logic                  Mvalid,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  MisalignM,
    output logic                  AccessFaultM,
    ysyx_23060184_lsu_if.master   dmem
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t                state, state_n, entry_state;
    logic                  accept, new_mis;
    logic                  aw_fire, w_fire, aw_done, w_done, aw_done_n, w_done_n;
    logic [1:0]            addr_lo_q;
    logic [2:0]            rop_q;
    logic [DATA_WIDTH-1:0] load_shift, load_ext, rd_data_n;
    logic                  mis_n, fault_n;

    assign Mready = (state == IDLE) | ((state == DONE) & Wready);
    assign accept = InValidM & Mready;

    // Decode of the instruction presented on the EX/MEM outputs; read wins over write.
    always_comb begin
        new_mis = 1'b0;
        if (MemReadM) begin
            case (RopcodeM)
                3'b001, 3'b101: new_mis = ALUResultM[0];
                3'b010:         new_mis = |ALUResultM[1:0];
                default:        new_mis = 1'b0;
            endcase
        end else if (MemWriteM) begin
            case (WmaskM)
                4'b0011: new_mis = ALUResultM[0];
                4'b1111: new_mis = |ALUResultM[1:0];
                default: new_mis = 1'b0;
            endcase
        end
        if (new_mis)        entry_state = DONE;
        else if (MemReadM)  entry_state = RD_ADDR;
        else if (MemWriteM) entry_state = WR_REQ;
        else                entry_state = DONE;
    end

    always_comb begin
        load_shift = dmem.rdata >> {addr_lo_q, 3'b000};
        case (rop_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_shift[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]};
            default: load_ext = dmem.rdata;
        endcase
    end

    always_comb begin
        state_n   = state;
        aw_fire   = dmem.awvalid & dmem.awready;
        w_fire    = dmem.wvalid & dmem.wready;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        case (state)
            IDLE:    if (InValidM) state_n = entry_state;
            RD_ADDR: if (dmem.arready) state_n = RD_DATA;
            RD_DATA: if (dmem.rvalid) state_n = DONE;
            WR_REQ: begin
                aw_done_n = aw_done | aw_fire;
                w_done_n  = w_done | w_fire;
                if (aw_done_n && w_done_n) state_n = WR_RESP;
            end
            WR_RESP: if (dmem.bvalid) state_n = DONE;
            DONE:    if (Wready) state_n = InValidM ? entry_state : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Result registers hold while DONE waits, clear when leaving it, and reload on
    // each completion (including a DONE->DONE back-to-back non-memory instruction).
    always_comb begin
        rd_data_n = ReadDataM;
        mis_n     = MisalignM;
        fault_n   = AccessFaultM;
        if (state_n != DONE) begin
            rd_data_n = '0;
            mis_n     = 1'b0;
            fault_n   = 1'b0;
        end
        if (accept && entry_state == DONE) begin
            rd_data_n = '0;
            mis_n     = new_mis;
            fault_n   = 1'b0;
        end
        if (state == RD_DATA && dmem.rvalid) begin
            fault_n   = |dmem.rresp;
            rd_data_n = fault_n ? '0 : load_ext;
            mis_n     = 1'b0;
        end
        if (state == WR_RESP && dmem.bvalid) begin
            fault_n   = |dmem.bresp;
            rd_data_n = '0;
            mis_n     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            addr_lo_q    <= '0;
            rop_q        <= '0;
            dmem.araddr  <= '0;
            dmem.arvalid <= 1'b0;
            dmem.rready  <= 1'b0;
            dmem.awaddr  <= '0;
            dmem.awvalid <= 1'b0;
            dmem.wdata   <= '0;
            dmem.wstrb   <= '0;
            dmem.wvalid  <= 1'b0;
            dmem.bready  <= 1'b0;
            Mvalid       <= 1'b0;
            ReadDataM    <= '0;
            MisalignM    <= 1'b0;
            AccessFaultM <= 1'b0;
        end else begin
            aw_done      <= aw_done_n;
            w_done       <= w_done_n;
            dmem.arvalid <= (state_n == RD_ADDR);
            dmem.rready  <= (state_n == RD_DATA);
            dmem.awvalid <= (state_n == WR_REQ) && !aw_done_n;
            dmem.wvalid  <= (state_n == WR_REQ) && !w_done_n;
            dmem.bready  <= (state_n == WR_RESP);
            Mvalid       <= (state_n == DONE);
            ReadDataM    <= rd_data_n;
            MisalignM    <= mis_n;
            AccessFaultM <= fault_n;
            if (accept) begin
                addr_lo_q <= ALUResultM[1:0];
                rop_q     <= RopcodeM;
                if (entry_state == RD_ADDR)
                    dmem.araddr <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                if (entry_state == WR_REQ) begin
                    dmem.awaddr <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                    dmem.wstrb  <= WmaskM << ALUResultM[1:0];
                    dmem.wdata  <= WriteDataM << {ALUResultM[1:0], 3'b000};
                end
            end
        end
    end

endmodule

// File: doc/ysyx_23060184_lsu.md
# ysyx_23060184_lsu

Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs and sits between that register and the MEM/WB register. For each instruction it runs a load or store transaction on an AXI4-Lite-style data-memory port, aligns and extends load data, and then offers the result downstream with a valid/ready handshake. It drives `Mready` back to the EX/MEM register and `Mvalid` forward to writeback.

## Interface
- `DATA_WIDTH`, 32, data/address width
- `clk` in 1: clock
- `resetn` in 1: asynchronous, active-low reset
- `InValidM` in 1: one-cycle strobe; EX/MEM register has just loaded a new instruction
- `MemReadM`, `MemWriteM` in 1: access type; neither set = non-memory instruction
- `RopcodeM` in 3: load kind, RISC-V funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- `WmaskM` in 4: store size (0001 byte, 0011 half, 1111 word)
- `ALUResultM` in 32: effective address
- `WriteDataM` in 32: store data, LSB-aligned
- `Wready` in 1: writeback accepts the result
- `Mready` out 1: LSU can accept a new instruction
- `Mvalid` out 1: result valid for writeback
- `ReadDataM` out 32: extended load data
- `MisalignM`, `AccessFaultM` out 1: exception flags, valid with `Mvalid`
- `araddr` out 32, `arvalid` out 1, `arready` in 1
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1
- `awaddr` out 32, `awvalid` out 1, `awready` in 1
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1
- `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, `InValidM`=1: capture the address, data, and controls.
  - Misaligned access goes to DONE with `MisalignM`=1 and issues no bus request. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise a read goes to RD_ADDR, a write goes to WR_REQ, and a non-memory instruction goes to DONE.
  - `MemReadM` and `MemWriteM` both set: read has priority.
- RD_ADDR: `arvalid`=1 and `araddr`={addr[31:2],2'b00}. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`:
  - Select the byte or half at addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU/LW.
  - If `rresp`≠0, set `AccessFaultM` and force `ReadDataM`=0.
  - Go to DONE.
- WR_REQ:
  - `awvalid` and `wvalid` are raised together.
  - `awaddr` is the word-aligned address.
  - `wstrb`=`WmaskM`<<addr[1:0].
  - `wdata`=`WriteDataM`<<(8·addr[1:0]).
  - AW and W handshakes complete independently in any order, or in the same cycle. Each valid drops after its own handshake.
  - When both are done, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, go to DONE; `bresp`≠0 sets `AccessFaultM`.
- DONE: `Mvalid`=1; outputs are held stable. On `Wready`, go to IDLE, or straight into the next access if `InValidM` is also high.
- `Mready` = (state==IDLE) | (state==DONE & `Wready`).
- `InValidM` while `Mready`=0 is a protocol violation; it is ignored.

## Timing
- All outputs are registered except `Mready`.
- On reset (async assert): state IDLE; all bus valids/readies 0; `Mvalid`=0; `ReadDataM`, address/data/strobe outputs 0; flags 0.
- Reset asserted mid-transaction aborts the transaction immediately. No valid stays high and no partial response is latched.
- Non-memory or misaligned instruction: `Mvalid` rises 1 cycle after the `InValidM` edge.
- Load with zero-wait slave: `arvalid` rises 1 cycle after `InValidM`; `rready` rises 1 cycle after the `arready` edge; `Mvalid` rises 1 cycle after `rvalid`. Minimum 3 cycles.
- Store minimum: 3 cycles, by the same pattern.
- Bus valids are held until handshake; address/data do not change while valid.
- Back-to-back operation: `Wready` and `InValidM` in the same DONE cycle give zero bubble cycles.

## Test plan
- LB at addr 0x80000003, `rdata`=0x80FFFFFF, zero-wait slave -> `ReadDataM`=0xFFFFFF80, `Mvalid` exactly 3 cycles after `InValidM`.
- SH at 0x80000002, `WriteDataM`=0x1234ABCD; `awready` is delayed 2 cycles and `wready` is immediate -> `wstrb`=1100, `wdata`=0xABCD0000, `awaddr`=0x80000000. `wvalid` drops after 1 cycle and `awvalid` after 3.
- LW at 0x80000001 -> `MisalignM`=1, `Mvalid` after 1 cycle, no `arvalid` ever asserted.
- LHU with `rresp`=2'b10 -> `AccessFaultM`=1, `ReadDataM`=0; held while `Wready`=0 for 4 cycles; cleared after `Wready`.
- Two back-to-back ADDs with `Wready`=1 -> `Mvalid` high on consecutive cycles, `Mready` never low.
- Store in progress, `resetn` pulsed low mid-WR_REQ -> `awvalid`/`wvalid` 0 within the reset cycle, state IDLE, `Mready`=1 after release.
